gon_opsum_drain: RTL

Downstream consumer of the GON (global output network) in the PE array. Walks every (row_tag, col_tag) pair of the configured mapping and requests each PE's opsum through the GON ready/enable handshake. Buffers each returned value in a 2-entry FIFO and writes it to the global buffer (GLB) at a computed address, honouring GLB back-pressure. Raises a one-cycle done pulse once the pass completes.

---
 rtl/gon_pkg.sv | 14 +
 rtl/gon_drain_fifo.sv | 36 +++
 rtl/gon_opsum_drain.sv | 92 +++++++++
 3 files changed

// File: rtl/gon_pkg.sv
// gon_pkg: shared sizes, drain FSM states and the GLB write record for the GON opsum drain
package gon_pkg;
  localparam int XBUS_NUMS = 12;
  localparam int PE_NUMS   = 14;
  localparam int ID_LEN    = 5;
  localparam int ROW_LEN   = 4;
  localparam int VALUE_LEN = 32;
  localparam int ADDR_LEN  = 16;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} drain_state_t;
  typedef struct packed {
    logic [ADDR_LEN-1:0]  addr;
    logic [VALUE_LEN-1:0] data;
  } opsum_wr_t;
endpackage

// File: rtl/gon_drain_fifo.sv
// gon_drain_fifo: 2-entry FIFO of GLB write records, async active-low reset
module gon_drain_fifo
  import gon_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  opsum_wr_t din,
  output opsum_wr_t dout,
  output logic [1:0] count,
  output logic      full,
  output logic      empty
);
  opsum_wr_t mem [2];
  logic wr_ptr, rd_ptr, do_push, do_pop;
  assign full    = count == 2'd2;
  assign empty   = count == 2'd0;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem    <= '{default: '0};
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= !wr_ptr;
      end
      if (do_pop) rd_ptr <= !rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
endmodule

// File: rtl/gon_opsum_drain.sv
// gon_opsum_drain: walks the PE mapping row-major, pulls opsums over the GON and
// writes them to the GLB through a 2-entry FIFO
module gon_opsum_drain
  import gon_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ROW_LEN-1:0]   cfg_rows,
  input  logic [ID_LEN-1:0]    cfg_cols,
  input  logic [ADDR_LEN-1:0]  cfg_base_addr,
  input  logic [ADDR_LEN-1:0]  cfg_row_stride,
  output logic                 busy,
  output logic                 done,
  output logic                 gon_ready,
  output logic [ROW_LEN-1:0]   gon_row_tag,
  output logic [ID_LEN-1:0]    gon_col_tag,
  input  logic                 gon_enable,
  input  logic [VALUE_LEN-1:0] gon_value,
  output logic                 glb_wr_en,
  output logic [ADDR_LEN-1:0]  glb_wr_addr,
  output logic [VALUE_LEN-1:0] glb_wr_data,
  input  logic                 glb_wr_ready
);
  drain_state_t state;
  logic [ROW_LEN-1:0]  rows_q;
  logic [ID_LEN-1:0]   cols_q;
  logic [ADDR_LEN-1:0] stride_q, row_base, addr;
  logic [1:0] count;
  logic full, empty, xfer, last_col, last;
  opsum_wr_t head;
  assign gon_ready   = state == ISSUE && !full;
  assign xfer        = gon_ready && gon_enable;
  assign last_col    = gon_col_tag == cols_q - 1'b1;
  assign last        = last_col && gon_row_tag == rows_q - 1'b1;
  assign busy        = state != IDLE;
  assign done        = state == FIN;
  assign glb_wr_en   = !empty;
  assign glb_wr_addr = head.addr;
  assign glb_wr_data = head.data;
  gon_drain_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (xfer),
    .pop   (glb_wr_ready),
    .din   ('{addr: addr, data: gon_value}),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  // addr tracks base + row*stride + col incrementally; row_base holds the row start
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      stride_q    <= '0;
      row_base    <= '0;
      addr        <= '0;
      gon_row_tag <= '0;
      gon_col_tag <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          rows_q      <= cfg_rows;
          cols_q      <= cfg_cols;
          stride_q    <= cfg_row_stride;
          row_base    <= cfg_base_addr;
          addr        <= cfg_base_addr;
          gon_row_tag <= '0;
          gon_col_tag <= '0;
          state       <= (cfg_rows == '0 || cfg_cols == '0) ? FIN : ISSUE;
        end
        ISSUE: if (xfer) begin
          if (last) state <= DRAIN;
          else if (last_col) begin
            gon_col_tag <= '0;
            gon_row_tag <= gon_row_tag + 1'b1;
            row_base    <= row_base + stride_q;
            addr        <= row_base + stride_q;
          end else begin
            gon_col_tag <= gon_col_tag + 1'b1;
            addr        <= addr + 1'b1;
          end
        end
        DRAIN: if (empty) state <= FIN;
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
